// File: rtl/snoop_ctrl.sv
// Bus snoop controller: looks up observed bus transactions in the cache and answers with
// hit/hitm, an optional write-back flush, and an invalidate for ownership requests.
module snoop_ctrl #(
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned FLUSH_TO = 15
) (
    input  logic              SCLK,
    input  logic              SRST,
    input  logic              BUS_REQ,
    input  logic              BUS_RW,
    input  logic [ADDR_W-1:0] BUS_ADDR,
    input  logic [1:0]        STATUS_I,
    input  logic              FLUSH_ACK,
    output logic              SNOOP_O,
    output logic [ADDR_W-1:0] ADDR_O,
    output logic              PHIT_O,
    output logic              PHITM_O,
    output logic              PINV_O,
    output logic              FLUSH_REQ,
    output logic              BUS_ACK,
    output logic              BUSY,
    output logic              ERR_O
);

    localparam int unsigned CntW = (FLUSH_TO > 0) ? $clog2(FLUSH_TO + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FLUSH_TO);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StCapture,
        StRespond,
        StFlush,
        StInval,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [1:0]        status_q, status_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              in_resp;

    always_ff @(posedge SCLK) begin
        if (!SRST) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            status_q <= 2'b00;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        status_d  = status_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        SNOOP_O   = 1'b0;
        PINV_O    = 1'b0;
        FLUSH_REQ = 1'b0;
        BUS_ACK   = 1'b0;

        case (state_q)
            StIdle: begin
                if (BUS_REQ) begin
                    addr_d  = BUS_ADDR;
                    rw_d    = BUS_RW;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                SNOOP_O = 1'b1;
                state_d = StCapture;
            end
            StCapture: begin
                status_d = STATUS_I;
                state_d  = StRespond;
            end
            StRespond: begin
                case (status_q)
                    2'b00: state_d = StDone;
                    2'b11: begin
                        cnt_d   = '0;
                        state_d = StFlush;
                    end
                    default: state_d = rw_q ? StDone : StInval;
                endcase
            end
            StFlush: begin
                FLUSH_REQ = 1'b1;
                // An ack arriving on the expiry cycle still counts as a successful flush.
                if (FLUSH_ACK || (cnt_q == CntMax)) begin
                    if (!FLUSH_ACK) begin
                        err_d = 1'b1;
                    end
                    state_d = rw_q ? StDone : StInval;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StInval: begin
                SNOOP_O = 1'b1;
                PINV_O  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                BUS_ACK = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Hit indications cover RESPOND through DONE, driven from the captured line state.
    assign in_resp = (state_q == StRespond) || (state_q == StFlush) ||
                     (state_q == StInval) || (state_q == StDone);
    assign PHIT_O  = in_resp && ((status_q == 2'b01) || (status_q == 2'b10));
    assign PHITM_O = in_resp && (status_q == 2'b11);
    assign BUSY    = (state_q != StIdle);
    assign ADDR_O  = addr_q;
    assign ERR_O   = err_q;

endmodule
